std_divmod_pipe: RTL

STD_DIVMOD_PIPE -- requirements
Module: std_divmod_pipe

---
 rtl/std_divmod_pkg.sv | 25 ++
 rtl/std_divmod_step.sv | 30 +++
 rtl/std_divmod_pipe.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/std_divmod_pkg.sv
// Shared types and configuration checks for the std_divmod_pipe divider.
package std_divmod_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Bit k set means k quotient bits per cycle is a supported setting.
  localparam logic [7:0] BPC_LEGAL_MASK = 8'b0001_0110;

  function automatic bit bpc_is_legal(input int unsigned bpc, input int unsigned width);
    bit ok;
    if (bpc > 32'd7) begin
      ok = 1'b0;
    end else if (width < 32'd2 || width > 32'd64) begin
      ok = 1'b0;
    end else begin
      ok = BPC_LEGAL_MASK[bpc[2:0]] && ((width % bpc) == 32'd0);
    end
    return ok;
  endfunction

endpackage

// File: rtl/std_divmod_step.sv
// One restoring shift-subtract step; chained to retire several quotient bits per cycle.
module std_divmod_step
  import std_divmod_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] divisor_ext_s;

  // Shift the next dividend bit into the partial remainder and try a subtract.
  always_comb begin
    shifted_s     = {rem_in, quo_in[WIDTH-1]};
    divisor_ext_s = {1'b0, divisor};
    if (shifted_s >= divisor_ext_s) begin
      rem_out = WIDTH'(shifted_s - divisor_ext_s);
      quo_out = {quo_in[WIDTH-2:0], 1'b1};
    end else begin
      rem_out = shifted_s[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/std_divmod_pipe.sv
// Iterative restoring divider (quotient and remainder) with go/done handshake.
// Define STD_DIVMOD_SELFCHECK_EN to build a simulation-only result checker.
module std_divmod_pipe
  import std_divmod_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int SIGNED         = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             done,
  output logic             div_by_zero
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]    LAST    = CW'(N - 1);
  localparam logic [CW-1:0]    CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    CNT_Z   = {CW{1'b0}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES    = {WIDTH{1'b1}};
  localparam bit IS_SIGNED = (SIGNED != 0);
  localparam bit CFG_OK    = bpc_is_legal(BITS_PER_CYCLE, WIDTH);

  if (!CFG_OK) begin : g_bad_cfg
    $error("std_divmod_pipe: illegal WIDTH/BITS_PER_CYCLE combination");
  end

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] rem_r, quo_r, dvs_r;
  logic             neg_q_r, neg_r_r;
  logic [WIDTH-1:0] quotient_r, remainder_r;
  logic             done_r, dbz_r;

  logic             left_neg_s, right_neg_s;
  logic [WIDTH-1:0] left_mag_s, right_mag_s, zero_quo_s;
  logic [WIDTH-1:0] quo_fin_s, rem_fin_s;
  logic [WIDTH-1:0] rem_chain_s [BITS_PER_CYCLE+1];
  logic [WIDTH-1:0] quo_chain_s [BITS_PER_CYCLE+1];

  // Operand magnitudes and the divide-by-zero quotient, used at the start edge.
  always_comb begin
    left_neg_s  = IS_SIGNED & left[WIDTH-1];
    right_neg_s = IS_SIGNED & right[WIDTH-1];
    if (left_neg_s) begin
      left_mag_s = ~left + ONE;
      zero_quo_s = ONE;
    end else begin
      left_mag_s = left;
      zero_quo_s = ONES;
    end
    if (right_neg_s) begin
      right_mag_s = ~right + ONE;
    end else begin
      right_mag_s = right;
    end
  end

  assign rem_chain_s[0] = rem_r;
  assign quo_chain_s[0] = quo_r;

  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    std_divmod_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem_chain_s[g]),
      .quo_in  (quo_chain_s[g]),
      .divisor (dvs_r),
      .rem_out (rem_chain_s[g+1]),
      .quo_out (quo_chain_s[g+1])
    );
  end

  // Re-apply signs to the last iteration's magnitudes (MIN / -1 wraps to MIN).
  always_comb begin
    if (neg_q_r) begin
      quo_fin_s = ~quo_chain_s[BITS_PER_CYCLE] + ONE;
    end else begin
      quo_fin_s = quo_chain_s[BITS_PER_CYCLE];
    end
    if (neg_r_r) begin
      rem_fin_s = ~rem_chain_s[BITS_PER_CYCLE] + ONE;
    end else begin
      rem_fin_s = rem_chain_s[BITS_PER_CYCLE];
    end
  end

  // Control FSM and datapath; FIN accepts a held go as the next request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_Z;
      rem_r       <= ZERO;
      quo_r       <= ZERO;
      dvs_r       <= ZERO;
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
      quotient_r  <= ZERO;
      remainder_r <= ZERO;
      done_r      <= 1'b0;
      dbz_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE, FIN: begin
          done_r <= 1'b0;
          if (go) begin
            cnt_r   <= CNT_Z;
            rem_r   <= ZERO;
            quo_r   <= left_mag_s;
            dvs_r   <= right_mag_s;
            neg_q_r <= left_neg_s ^ right_neg_s;
            neg_r_r <= left_neg_s;
            if (right == ZERO) begin
              state_r     <= FIN;
              done_r      <= 1'b1;
              quotient_r  <= zero_quo_s;
              remainder_r <= left;
              dbz_r       <= 1'b1;
            end else begin
              state_r <= RUN;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (!go) begin
            state_r <= IDLE;
          end else begin
            rem_r <= rem_chain_s[BITS_PER_CYCLE];
            quo_r <= quo_chain_s[BITS_PER_CYCLE];
            if (cnt_r == LAST) begin
              state_r     <= FIN;
              done_r      <= 1'b1;
              quotient_r  <= quo_fin_s;
              remainder_r <= rem_fin_s;
              dbz_r       <= 1'b0;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign out_quotient  = quotient_r;
  assign out_remainder = remainder_r;
  assign done          = done_r;
  assign div_by_zero   = dbz_r;

`ifdef STD_DIVMOD_SELFCHECK_EN
  logic start_s;
  assign start_s = go && ((state_r == IDLE) || (state_r == FIN));

  std_divmod_selfcheck #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_selfcheck (
    .clk       (clk),
    .start     (start_s),
    .left      (left),
    .right     (right),
    .quotient  (quotient_r),
    .remainder (remainder_r),
    .done      (done_r)
  );
`endif

endmodule

`ifdef STD_DIVMOD_SELFCHECK_EN
// Simulation-only comparison of each completed result against "/" and "%".
module std_divmod_selfcheck #(
  parameter int WIDTH  = 32,
  parameter int SIGNED = 0
) (
  input logic             clk,
  input logic             start,
  input logic [WIDTH-1:0] left,
  input logic [WIDTH-1:0] right,
  input logic [WIDTH-1:0] quotient,
  input logic [WIDTH-1:0] remainder,
  input logic             done
);
  localparam logic [WIDTH-1:0] MIN  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  logic [WIDTH-1:0] l_r, r_r, exp_q_s, exp_r_s;
  logic             skip_s;

  // Reference result for the operands captured at the last start.
  always_comb begin
    skip_s = (r_r == ZERO) || ((SIGNED != 0) && (l_r == MIN) && (r_r == ONES));
    if (skip_s) begin
      exp_q_s = ZERO;
      exp_r_s = ZERO;
    end else if (SIGNED != 0) begin
      exp_q_s = WIDTH'($signed(l_r) / $signed(r_r));
      exp_r_s = WIDTH'($signed(l_r) % $signed(r_r));
    end else begin
      exp_q_s = l_r / r_r;
      exp_r_s = l_r % r_r;
    end
  end

  // Compare on done before a same-edge restart overwrites the operands.
  always @(posedge clk) begin
    if (done && !skip_s && ((quotient !== exp_q_s) || (remainder !== exp_r_s))) begin
      $error("std_divmod_selfcheck: %h/%h gave q=%h r=%h, expected q=%h r=%h",
             l_r, r_r, quotient, remainder, exp_q_s, exp_r_s);
    end
    if (start) begin
      l_r <= left;
      r_r <= right;
    end
  end
endmodule
`endif
